// File: rtl/dat_mem_master.sv
// Initiator for the 8-row data memory: turns load/store/copy requests into
// single-cycle ADDR/WriteDat/WEN/REN accesses and returns one response per request.
module dat_mem_master #(
  parameter int width   = 16,
  parameter int rowData = 8,
  parameter int lenW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_OP,
  input  logic [width-1:0] REQ_ADDR,
  input  logic [width-1:0] REQ_DST,
  input  logic [lenW-1:0]  REQ_LEN,
  input  logic [width-1:0] REQ_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [width-1:0] RSP_DATA,
  output logic             RSP_ERR,
  output logic             BUSY,
  output logic [width-1:0] ADDR,
  output logic [width-1:0] WriteDat,
  output logic             WEN,
  output logic             REN,
  input  logic [width-1:0] ReadDat
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
  // valid and its payload are held unchanged until that edge.

  if (rowData < 2 || (rowData & (rowData - 1)) != 0) begin : g_bad_rowdata
    $error("rowData must be a power of two of at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STORE = 3'd2,
    S_CP_RD = 3'd3,
    S_CP_WR = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t           r_state;
  logic [width-1:0] r_src;
  logic [width-1:0] r_dst;
  logic [lenW-1:0]  r_cnt;
  logic [width-1:0] r_buf;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [width-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             r_busy;
  logic [width-1:0] r_addr;
  logic [width-1:0] r_wdat;
  logic             r_wen;
  logic             r_ren;

  // Every output is a register set one edge ahead, so strobes line up with states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_wdat      <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_src       <= REQ_ADDR;
            r_dst       <= REQ_DST;
            r_cnt       <= REQ_LEN;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (REQ_OP)
              OP_LOAD: begin
                r_state <= S_LOAD;
                r_ren   <= 1'b1;
                r_addr  <= REQ_ADDR;
              end
              OP_STORE: begin
                r_state <= S_STORE;
                r_wen   <= 1'b1;
                r_addr  <= REQ_ADDR;
                r_wdat  <= REQ_WDATA;
              end
              OP_COPY: begin
                if (REQ_LEN != '0) begin
                  r_state <= S_CP_RD;
                  r_ren   <= 1'b1;
                  r_addr  <= REQ_ADDR;
                end else begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                end
              end
              default: begin
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_data  <= '0;
              end
            endcase
          end
        end
        S_LOAD: begin
          r_rsp_data  <= ReadDat;
          r_ren       <= 1'b0;
          r_addr      <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_STORE: begin
          r_rsp_data  <= '0;
          r_wen       <= 1'b0;
          r_addr      <= '0;
          r_wdat      <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_CP_RD: begin
          r_buf   <= ReadDat;
          r_wdat  <= ReadDat;
          r_ren   <= 1'b0;
          r_wen   <= 1'b1;
          r_addr  <= r_dst;
          r_state <= S_CP_WR;
        end
        S_CP_WR: begin
          // Strictly forward, one word at a time, so overlapping ranges replicate.
          r_src  <= r_src + 1'b1;
          r_dst  <= r_dst + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          r_wen  <= 1'b0;
          r_wdat <= '0;
          if (r_cnt == lenW'(1)) begin
            r_rsp_data  <= r_buf;
            r_rsp_valid <= 1'b1;
            r_addr      <= '0;
            r_state     <= S_RESP;
          end else begin
            r_ren   <= 1'b1;
            r_addr  <= r_src + 1'b1;
            r_state <= S_CP_RD;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_ERR   = r_rsp_err;
  assign BUSY      = r_busy;
  assign ADDR      = r_addr;
  assign WriteDat  = r_wdat;
  assign WEN       = r_wen;
  assign REN       = r_ren;

endmodule

// File: tb/tb_dat_mem_master.sv
// Directed bench for dat_mem_master with a behavioural 8-row memory attached
// to the strobe outputs; expected values are hand-computed constants.
module tb_dat_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_dst;
  logic [3:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic        wen;
  logic        ren;
  logic [15:0] rdat;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dat_mem_master #(.width(16), .rowData(8), .lenW(4)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_ADDR(req_addr), .REQ_DST(req_dst), .REQ_LEN(req_len), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .BUSY(busy), .ADDR(addr), .WriteDat(wdat), .WEN(wen), .REN(ren), .ReadDat(rdat)
  );

  // Behavioural memory: row = low 3 address bits, write on posedge, async read.
  logic [15:0] mem [8];
  logic        tb_we;
  logic [2:0]  tb_wa;
  logic [15:0] tb_wd;

  always @(posedge clk) begin
    if (wen) mem[addr[2:0]] <= wdat;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end
  assign rdat = ren ? mem[addr[2:0]] : 16'h0000;

  // Strobe monitors sampled mid-cycle.
  logic mon_en = 1'b0;
  int   wen_cnt = 0;
  int   ren_cnt = 0;
  int   both_cnt = 0;
  int   idle_viol = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen) wen_cnt++;
      if (ren) ren_cnt++;
      if (wen && ren) both_cnt++;
      if ((!busy || rsp_valid) && (wen || ren || addr != 16'h0 || wdat != 16'h0)) idle_viol++;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Presents one request in IDLE; returns just after the accepting posedge.
  task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] len, input logic [15:0] wd);
    @(negedge clk);
    check("req_ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_dst = d; req_len = len; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  int w0, r0, n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_dst = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    poke(3'd0, 16'h0010); poke(3'd1, 16'h1111); poke(3'd2, 16'h2222); poke(3'd3, 16'h3333);
    poke(3'd4, 16'h4444); poke(3'd5, 16'h00A5); poke(3'd6, 16'h0006); poke(3'd7, 16'h0007);

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {14'h0, wen, ren}, 16'h0);
    check("rst_addr", addr, 16'h0);
    check("rst_wdat", wdat, 16'h0);
    check("rst_rsp_data", rsp_data, 16'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Load addr 5 with response backpressure
    r0 = ren_cnt;
    do_req(2'b00, 16'd5, 16'd0, 4'd0, 16'h0);
    @(negedge clk);
    check("load_ren", ren, 1'b1);
    check("load_addr", addr, 16'd5);
    check("load_busy", busy, 1'b1);
    check("load_no_rsp_yet", rsp_valid, 1'b0);
    @(negedge clk);
    check("load_rsp_valid", rsp_valid, 1'b1);
    check("load_rsp_data", rsp_data, 16'h00A5);
    check("load_rsp_err", rsp_err, 1'b0);
    check("load_ren_pulses", 16'(ren_cnt - r0), 16'd1);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 16'd5; req_wdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, 16'h00A5);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_no_wen", wen, 1'b0);
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_ready", req_ready, 1'b1);
    check("bp_release_busy", busy, 1'b0);
    check("bp_store_ignored", mem[5], 16'h00A5);

    // Store 1234 to addr 3, then load it back
    w0 = wen_cnt;
    do_req(2'b01, 16'd3, 16'd0, 4'd0, 16'h1234);
    @(negedge clk);
    check("store_wen", wen, 1'b1);
    check("store_addr", addr, 16'd3);
    check("store_wdat", wdat, 16'h1234);
    @(negedge clk);
    check("store_rsp_valid", rsp_valid, 1'b1);
    check("store_rsp_data", rsp_data, 16'h0000);
    check("store_wen_pulses", 16'(wen_cnt - w0), 16'd1);
    finish_rsp();
    do_req(2'b00, 16'd3, 16'd0, 4'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check("reload_rsp_data", rsp_data, 16'h1234);
    finish_rsp();

    // Copy src=6 dst=1 len=3, wrapping 7 -> 0
    w0 = wen_cnt; r0 = ren_cnt; n = 0;
    do_req(2'b10, 16'd6, 16'd1, 4'd3, 16'h0);
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("copy_rsp_valid", rsp_valid, 1'b1);
    check("copy_busy_cycles", 16'(n), 16'd6);
    check("copy_rsp_data", rsp_data, 16'h0010);
    check("copy_wen_pulses", 16'(wen_cnt - w0), 16'd3);
    check("copy_ren_pulses", 16'(ren_cnt - r0), 16'd3);
    finish_rsp();
    check("copy_mem1", mem[1], 16'h0006);
    check("copy_mem2", mem[2], 16'h0007);
    check("copy_mem3", mem[3], 16'h0010);

    // Zero-length copy and reserved opcode
    w0 = wen_cnt; r0 = ren_cnt;
    do_req(2'b10, 16'd2, 16'd4, 4'd0, 16'h0);
    @(negedge clk);
    check("len0_rsp_valid", rsp_valid, 1'b1);
    check("len0_rsp_data", rsp_data, 16'h0000);
    check("len0_rsp_err", rsp_err, 1'b0);
    finish_rsp();
    do_req(2'b11, 16'd2, 16'd4, 4'd2, 16'hBEEF);
    @(negedge clk);
    check("err_rsp_valid", rsp_valid, 1'b1);
    check("err_rsp_err", rsp_err, 1'b1);
    check("err_rsp_data", rsp_data, 16'h0000);
    finish_rsp();
    @(negedge clk);
    check("err_cleared", rsp_err, 1'b0);
    check("err_valid_cleared", rsp_valid, 1'b0);
    check("noaccess_strobes", 16'((wen_cnt - w0) + (ren_cnt - r0)), 16'd0);

    // Reset during CP_WR of word 2 of a 4-word copy
    poke(3'd4, 16'hAAAA); poke(3'd5, 16'hBBBB); poke(3'd6, 16'hCCCC); poke(3'd7, 16'hDDDD);
    poke(3'd0, 16'hEEEE); poke(3'd1, 16'hEEEE); poke(3'd2, 16'hEEEE); poke(3'd3, 16'hEEEE);
    do_req(2'b10, 16'd4, 16'd0, 4'd4, 16'h0);
    repeat (4) @(negedge clk);
    check("midcopy_wen", wen, 1'b1);
    check("midcopy_addr", addr, 16'd1);
    check("midcopy_wdat", wdat, 16'hBBBB);
    #1 rst = 1'b1;
    #1;
    check("async_rst_req_ready", req_ready, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_strobes", {14'h0, wen, ren}, 16'h0);
    check("async_rst_addr", addr, 16'h0);
    check("async_rst_wdat", wdat, 16'h0);
    check("async_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("partial_mem0", mem[0], 16'hAAAA);
    check("partial_mem1", mem[1], 16'hEEEE);
    check("partial_mem2", mem[2], 16'hEEEE);
    repeat (3) @(negedge clk);
    check("no_rsp_after_abort", rsp_valid, 1'b0);
    check("post_abort_idle", req_ready, 1'b1);

    check("wen_ren_exclusive", 16'(both_cnt), 16'd0);
    check("idle_resp_bus_quiet", 16'(idle_viol), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dat_mem_master.md
Name: dat_mem_master

Overview:
- Initiator side of the data-memory port: accepts load, store and block-copy requests from the core over a valid/ready request channel.
- Sequences the ADDR / WriteDat / WEN / REN strobes into the 8-row data memory and returns results on a valid/ready response channel.
- Sits between the execute stage and the data memory; it is the only driver of the memory's address, write-data and strobe inputs.

Parameters:
- width, 16, data and address bus width (matches gP::width).
- rowData, 8, number of memory rows; only the low log2(rowData) address bits select a row.
- lenW, 4, width of the copy length field.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- REQ_OP  in  2  00 load, 01 store, 10 copy, 11 reserved.
- REQ_ADDR  in  width  load/store address, or copy source.
- REQ_DST  in  width  copy destination base.
- REQ_LEN  in  lenW  copy word count.
- REQ_WDATA  in  width  store data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  width  load data, or last copied word; 0 for store and error.
- RSP_ERR  out  1  reserved opcode.
- BUSY  out  1  high in any state other than IDLE.
- ADDR  out  width  memory address.
- WriteDat  out  width  memory write data.
- WEN  out  1  memory write strobe; memory writes on posedge while high.
- REN  out  1  memory read strobe; ReadDat is combinationally valid while high.
- ReadDat  in  width  memory read data.

Behaviour:
- **Reset:** state=IDLE. REQ_READY=1; RSP_VALID, RSP_ERR, BUSY, WEN, REN = 0; RSP_DATA, ADDR, WriteDat = 0; internal latches and counters = 0.
- **Reset mid-operation:** aborts immediately. Words already written by a partial copy remain in memory, and no response is issued.
- **States:** IDLE, LOAD, STORE, CP_RD, CP_WR, RESP. One request is outstanding at a time.
- **IDLE:**
  - REQ_READY=1. A request is accepted on a posedge with REQ_VALID=1, and all REQ_* fields are latched.
  - Next state: op 00 → LOAD; op 01 → STORE; op 10 with LEN>0 → CP_RD; op 10 with LEN=0 → RESP (RSP_DATA=0, no memory access); op 11 → RESP with RSP_ERR=1 (no memory access).
- **LOAD (1 cycle):** REN=1, ADDR=latched addr. RSP_DATA<=ReadDat at the posedge; → RESP.
- **STORE (1 cycle):** WEN=1, ADDR=addr, WriteDat=wdata. RSP_DATA<=0; → RESP.
- **CP_RD (1 cycle):** REN=1, ADDR=src. buf<=ReadDat; → CP_WR.
- **CP_WR (1 cycle):** WEN=1, ADDR=dst, WriteDat=buf. At the posedge: src+=1, dst+=1 (mod 2^width), cnt-=1.
  - If cnt was 1: RSP_DATA<=buf, → RESP.
  - Otherwise → CP_RD.
- **Copy timing:** a copy of N words takes 2N busy cycles.
- **Copy address wrap and overlap:** the row index wraps 7→0 naturally via the low bits. Copy is strictly forward, word by word. Overlapping ranges are therefore defined, e.g. src=0, dst=1 replicates mem[0] forward.
- **RESP:** RSP_VALID=1; RSP_DATA and RSP_ERR are held stable until a posedge with RSP_READY=1, then → IDLE with RSP_VALID=0 and RSP_ERR=0. REQ_READY=0 throughout.
- **Latency:** request accepted at edge k → RSP_VALID high after edge k+2 for load/store, k+1 for error or LEN=0, k+1+2N for copy.
- **Strobe rules:**
  - WEN and REN are never both 1.
  - Both are 0 in IDLE and RESP, and ADDR and WriteDat are driven 0 in those states.
  - Each strobe is high for exactly one cycle per access.
- **Same-edge handshakes:** a request and a response handshake never occur on the same edge, since REQ_READY is 0 in RESP.

Test Plan:
- **Load:** preload mem[5]=16'h00A5; load addr 5 → one cycle with REN=1, ADDR=5; RSP_VALID two cycles after accept, RSP_DATA=16'h00A5, RSP_ERR=0.
- **Store then load:** store 16'h1234 to addr 3 → one WEN pulse, RSP_DATA=0; a following load of 3 returns 16'h1234.
- **Copy with wrap:** mem[6]=16'h0006, mem[7]=16'h0007, mem[0]=16'h0010; copy src=6, dst=1, LEN=3 → mem[1..3]={0006,0007,0010}, 6 busy cycles, RSP_DATA=16'h0010.
- **Zero-length and reserved ops:** copy LEN=0 → response the cycle after accept, no WEN/REN; op 11 → RSP_ERR=1, RSP_DATA=0, no strobes.
- **Response backpressure:** hold RSP_READY=0 for 5 cycles after a load → RSP_VALID and RSP_DATA stable, REQ_READY=0, new REQ_VALID ignored; raise RSP_READY → IDLE next edge.
- **Reset mid-copy:** assert RST asynchronously during CP_WR of word 2 of a LEN=4 copy → all outputs 0 and REQ_READY=1 immediately; only the first words are written, and no response is issued.
